// File: rtl/rgb_pwm_sequencer.sv
// rtl/rgb_pwm_sequencer.sv - three-channel RGB PWM generator with prescaler and blink sequencer
`timescale 1ns/1ps
module rgb_pwm_sequencer #(
   parameter int PSC_W   = 16,
   parameter int BLINK_W = 16
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        wr_valid,
   input  logic [2:0]  wr_addr,
   input  logic [15:0] wr_data,
   output logic [2:0]  pwm_out,
   output logic        period_tick,
   output logic [1:0]  seq_state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ON   = 2'd1,
      ST_OFF  = 2'd2
   } state_t;

   logic [7:0]         duty_r, duty_g, duty_b;
   logic [PSC_W-1:0]   prescale;
   logic               enable, blink_en;
   logic [BLINK_W-1:0] on_time, off_time;

   state_t             state, state_nxt;
   logic [PSC_W-1:0]   psc_cnt, psc_nxt;
   logic [7:0]         pwm_cnt, pwm_nxt;
   logic [BLINK_W-1:0] blink_cnt, blink_nxt;
   logic [2:0][7:0]    shadow;
   logic               load_shadow, tick_nxt, tick, wrap;
   logic [2:0]         pwm_cmp, out_nxt;
   logic [BLINK_W:0]   blink_inc, on_limit, off_limit;

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         duty_r   <= '0;
         duty_g   <= '0;
         duty_b   <= '0;
         prescale <= '0;
         enable   <= 1'b0;
         blink_en <= 1'b0;
         on_time  <= '0;
         off_time <= '0;
      end else if (wr_valid) begin
         case (wr_addr)
            3'd0: duty_r   <= wr_data[7:0];
            3'd1: duty_g   <= wr_data[7:0];
            3'd2: duty_b   <= wr_data[7:0];
            3'd3: prescale <= wr_data[PSC_W-1:0];
            3'd4: begin
               enable   <= wr_data[0];
               blink_en <= wr_data[1];
            end
            3'd5: on_time  <= wr_data[BLINK_W-1:0];
            3'd6: off_time <= wr_data[BLINK_W-1:0];
            default: ;
         endcase
      end
   end

   // ">=" so that lowering PRESCALE below the running count still ticks promptly
   assign tick      = (state != ST_IDLE) && (psc_cnt >= prescale);
   assign wrap      = tick && (pwm_cnt == 8'hff);
   assign blink_inc = {1'b0, blink_cnt} + {{BLINK_W{1'b0}}, 1'b1};
   assign on_limit  = (on_time == '0)  ? {{BLINK_W{1'b0}}, 1'b1} : {1'b0, on_time};
   assign off_limit = (off_time == '0) ? {{BLINK_W{1'b0}}, 1'b1} : {1'b0, off_time};
   assign pwm_cmp   = {pwm_cnt < shadow[2], pwm_cnt < shadow[1], pwm_cnt < shadow[0]};

   always_comb begin
      state_nxt   = state;
      psc_nxt     = tick ? '0 : psc_cnt + PSC_W'(1);
      pwm_nxt     = pwm_cnt + {7'd0, tick};
      blink_nxt   = blink_cnt;
      load_shadow = wrap;
      tick_nxt    = wrap;
      out_nxt     = 3'b000;
      case (state)
         ST_IDLE: begin
            psc_nxt   = '0;
            pwm_nxt   = '0;
            blink_nxt = '0;
            if (enable) begin
               state_nxt   = ST_ON;
               load_shadow = 1'b1;
            end
         end
         ST_ON: begin
            out_nxt = pwm_cmp;
            if (!blink_en) begin
               blink_nxt = '0;
            end else if (wrap) begin
               if (blink_inc >= on_limit) begin
                  state_nxt = ST_OFF;
                  blink_nxt = '0;
               end else begin
                  blink_nxt = blink_inc[BLINK_W-1:0];
               end
            end
         end
         ST_OFF: begin
            if (!blink_en) begin
               state_nxt = ST_ON;
               blink_nxt = '0;
            end else if (wrap) begin
               if (blink_inc >= off_limit) begin
                  state_nxt = ST_ON;
                  blink_nxt = '0;
               end else begin
                  blink_nxt = blink_inc[BLINK_W-1:0];
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      // Disable overrides everything and parks the block with cleared counters
      if (!enable) begin
         state_nxt   = ST_IDLE;
         psc_nxt     = '0;
         pwm_nxt     = '0;
         blink_nxt   = '0;
         load_shadow = 1'b0;
         tick_nxt    = 1'b0;
         out_nxt     = 3'b000;
      end
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state       <= ST_IDLE;
         psc_cnt     <= '0;
         pwm_cnt     <= '0;
         blink_cnt   <= '0;
         shadow      <= '0;
         pwm_out     <= 3'b000;
         period_tick <= 1'b0;
      end else begin
         state       <= state_nxt;
         psc_cnt     <= psc_nxt;
         pwm_cnt     <= pwm_nxt;
         blink_cnt   <= blink_nxt;
         if (load_shadow) shadow <= {duty_b, duty_g, duty_r};
         pwm_out     <= out_nxt;
         period_tick <= tick_nxt;
      end
   end

   assign seq_state = state;

endmodule

// File: tb/tb_rgb_pwm_sequencer.sv
// tb/tb_rgb_pwm_sequencer.sv - scoreboard bench for rgb_pwm_sequencer with a period-level model
`timescale 1ns/1ps
module tb_rgb_pwm_sequencer;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic        wr_valid;
   logic [2:0]  wr_addr;
   logic [15:0] wr_data;
   logic [2:0]  pwm_out;
   logic        period_tick;
   logic [1:0]  seq_state;

   rgb_pwm_sequencer #(.PSC_W(16), .BLINK_W(16)) dut (
      .HCLK        (HCLK),
      .HRESET      (HRESET),
      .wr_valid    (wr_valid),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .pwm_out     (pwm_out),
      .period_tick (period_tick),
      .seq_state   (seq_state)
   );

   always #5 HCLK = ~HCLK;

   typedef struct {
      int st;
      int hi_r;
      int hi_g;
      int hi_b;
      int len;
   } exp_t;

   typedef struct {
      int per;
      int cyc;
      int addr;
      int data;
   } wr_t;

   exp_t sb[$];
   wr_t  plan[$];
   int   checks = 0;
   int   passed = 0;

   // period-level reference model: registers, shadow duty, phase and phase count
   int m_duty[3];
   int m_sh[3];
   int m_psc, m_on, m_off, m_st, m_cnt;
   bit m_blink;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act == req) passed++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_duty[i] = 0;
         m_sh[i]   = 0;
      end
      m_psc = 0; m_on = 0; m_off = 0; m_st = 0; m_cnt = 0; m_blink = 0;
   endtask

   task automatic apply_model(input int addr, input int data);
      case (addr)
         0, 1, 2: m_duty[addr] = data % 256;
         3:       m_psc = data % 65536;
         5:       m_on  = data % 65536;
         6:       m_off = data % 65536;
         default: ;
      endcase
   endtask

   task automatic step();
      @(posedge HCLK);
      #1;
   endtask

   task automatic wr_cycle(input int addr, input int data);
      wr_valid = 1'b1;
      wr_addr  = 3'(addr);
      wr_data  = 16'(data);
      step();
      wr_valid = 1'b0;
   endtask

   task automatic cfg(input int addr, input int data);
      wr_cycle(addr, data);
      apply_model(addr, data);
   endtask

   task automatic start(input bit blink);
      wr_cycle(4, blink ? 3 : 1);
      step();
      m_blink = blink;
      m_st    = 1;
      m_cnt   = 0;
      for (int i = 0; i < 3; i++) m_sh[i] = m_duty[i];
   endtask

   function automatic int find_wr(input int p, input int c);
      foreach (plan[i]) if (plan[i].per == p && plan[i].cyc == c) return i;
      return -1;
   endfunction

   task automatic run_periods(input int n);
      int L;
      int idx;
      int pend;
      exp_t e;
      L = 256 * (m_psc + 1);
      for (int p = 0; p < n; p++) begin
         e.st   = m_st;
         e.hi_r = (m_st == 1) ? m_sh[0] * (m_psc + 1) : 0;
         e.hi_g = (m_st == 1) ? m_sh[1] * (m_psc + 1) : 0;
         e.hi_b = (m_st == 1) ? m_sh[2] * (m_psc + 1) : 0;
         e.len  = L;
         sb.push_back(e);
         pend = -1;
         for (int c = 0; c < L; c++) begin
            idx = find_wr(p, c);
            if (idx >= 0) begin
               wr_valid = 1'b1;
               wr_addr  = 3'(plan[idx].addr);
               wr_data  = 16'(plan[idx].data);
               if (c == L - 1) pend = idx;
               else apply_model(plan[idx].addr, plan[idx].data);
            end
            step();
            wr_valid = 1'b0;
         end
         // period boundary: shadows latch, blink phase advances, then late writes land
         for (int i = 0; i < 3; i++) m_sh[i] = m_duty[i];
         if (m_st == 1 && m_blink) begin
            m_cnt++;
            if (m_cnt >= ((m_on == 0) ? 1 : m_on)) begin m_st = 2; m_cnt = 0; end
         end else if (m_st == 2) begin
            m_cnt++;
            if (m_cnt >= ((m_off == 0) ? 1 : m_off)) begin m_st = 1; m_cnt = 0; end
         end
         if (pend >= 0) apply_model(plan[pend].addr, plan[pend].data);
      end
      plan.delete();
   endtask

   task automatic stop(input int delay);
      for (int i = 0; i < delay; i++) step();
      wr_cycle(4, 0);
      step();
      check("disable_state", int'(seq_state), 0);
      check("disable_pwm", int'(pwm_out), 0);
      m_st = 0;
   endtask

   // monitor: each PWM period is a window opened by period_tick or by leaving IDLE
   bit         w_open = 1'b0;
   int         w_len, w_hr, w_hg, w_hb, w_bad;
   logic [1:0] w_st;
   logic [1:0] prev_st = 2'd0;
   exp_t       got;

   always @(negedge HCLK) begin
      if (HRESET) begin
         w_open = 1'b0;
      end else begin
         if (period_tick) begin
            check("tick_in_window", int'(w_open), 1);
            if (w_open) begin
               check("expected_available", int'(sb.size() != 0), 1);
               if (sb.size() != 0) begin
                  got = sb.pop_front();
                  check("period_state", int'(w_st), got.st);
                  check("period_len", w_len, got.len);
                  check("high_r", w_hr, got.hi_r);
                  check("high_g", w_hg, got.hi_g);
                  check("high_b", w_hb, got.hi_b);
                  check("state_stable", w_bad, 0);
               end
            end
         end
         if (period_tick || (seq_state != 2'd0 && prev_st == 2'd0)) begin
            w_open = 1'b1;
            w_st   = seq_state;
            w_len  = 1;
            w_hr   = int'(pwm_out[0]);
            w_hg   = int'(pwm_out[1]);
            w_hb   = int'(pwm_out[2]);
            w_bad  = 0;
         end else if (seq_state == 2'd0) begin
            w_open = 1'b0;
         end else if (w_open) begin
            w_len++;
            w_hr += int'(pwm_out[0]);
            w_hg += int'(pwm_out[1]);
            w_hb += int'(pwm_out[2]);
            if (seq_state != w_st) w_bad++;
         end
      end
      prev_st = HRESET ? 2'd0 : seq_state;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int ticks, his, sts, L, nw, sel, a, d;
      wr_t w;
      int addr_tab[6];
      addr_tab[0] = 0; addr_tab[1] = 1; addr_tab[2] = 2;
      addr_tab[3] = 5; addr_tab[4] = 6; addr_tab[5] = 7;
      HRESET = 1'b1; wr_valid = 1'b0; wr_addr = 3'd0; wr_data = 16'd0;
      model_reset();
      repeat (3) step();
      check("reset_pwm", int'(pwm_out), 0);
      check("reset_tick", int'(period_tick), 0);
      check("reset_state", int'(seq_state), 0);
      HRESET = 1'b0;

      ticks = 0; his = 0; sts = 0;
      repeat (1000) begin
         step();
         if (period_tick) ticks++;
         if (pwm_out != 3'b000) his++;
         if (seq_state != 2'd0) sts++;
      end
      check("idle_ticks", ticks, 0);
      check("idle_pwm", his, 0);
      check("idle_state", sts, 0);

      // red at 64/256, no prescale
      cfg(0, 64); cfg(3, 0);
      start(0); run_periods(3); stop(0);

      // green duty change mid-period and on the wrap cycle
      cfg(0, 0); cfg(1, 128);
      start(0);
      w.per = 0; w.cyc = 100; w.addr = 1; w.data = 32;  plan.push_back(w);
      w.per = 1; w.cyc = 50;  w.addr = 1; w.data = 128; plan.push_back(w);
      w.per = 2; w.cyc = 255; w.addr = 1; w.data = 32;  plan.push_back(w);
      run_periods(5); stop(0);

      // blue at full duty with prescale 3
      cfg(1, 0); cfg(2, 255); cfg(3, 3);
      start(0); run_periods(3); stop(0);

      // blink ON 2 / OFF 1, then disable mid-period while high
      cfg(2, 0); cfg(3, 0); cfg(0, 100); cfg(5, 2); cfg(6, 0);
      start(1); run_periods(6); stop(37);

      // async reset mid-period, then configuration must be gone
      cfg(0, 200); cfg(5, 0);
      start(0); run_periods(1);
      repeat (20) step();
      #2 HRESET = 1'b1;
      #1;
      check("async_reset_pwm", int'(pwm_out), 0);
      check("async_reset_tick", int'(period_tick), 0);
      check("async_reset_state", int'(seq_state), 0);
      step();
      HRESET = 1'b0;
      sb.delete();
      model_reset();
      step();
      check("post_reset_state", int'(seq_state), 0);
      start(0); run_periods(1); stop(5);

      // randomized epochs
      for (int ep = 0; ep < 6; ep++) begin
         cfg(0, $urandom_range(0, 255));
         cfg(1, $urandom_range(0, 255));
         cfg(2, $urandom_range(0, 255));
         cfg(3, $urandom_range(0, 2));
         cfg(5, $urandom_range(0, 3));
         cfg(6, $urandom_range(0, 3));
         L = 256 * (m_psc + 1);
         for (int p = 0; p < 4; p++) begin
            nw = $urandom_range(0, 2);
            for (int k = 0; k < nw; k++) begin
               sel = $urandom_range(0, 5);
               a   = addr_tab[sel];
               d   = (a == 5 || a == 6) ? $urandom_range(0, 3) : $urandom_range(0, 65535);
               w.per  = p;
               w.cyc  = ($urandom_range(0, 3) == 0) ? L - 1 : $urandom_range(0, L - 2);
               w.addr = a;
               w.data = d;
               plan.push_back(w);
            end
         end
         start($urandom_range(0, 1) == 1);
         run_periods(4);
         stop($urandom_range(0, L - 3));
      end

      repeat (10) step();
      check("scoreboard_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
